svc_stream_arb: RTL and testbench

Round-robin arbiter sharing one valid/ready output stream between NUM_SRC requesting streams. Each requester drives a valid/ready/data/last beat; the arbiter selects one source per accepted beat, or per packet when locking is compiled in, and forwards it through a registered skid buffer. It sits in front of any single-consumer datapath (memory port, serializer, FIFO) that several producers must share without combinational ready paths leaking between them.

---
 rtl/svc_stream_arb_pkg.sv | 19 +
 rtl/svc_stream_arb_if.sv | 30 +++
 rtl/svc_skidbuf.sv | 103 ++++++++++
 rtl/svc_stream_arb.sv | 165 ++++++++++++++++
 tb/tb_svc_stream_arb.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/svc_stream_arb_pkg.sv
// svc_stream_arb_pkg: shared types and helpers for the stream arbiter.
// Holds the packet-lock state encoding and the modulo source-index increment.
package svc_stream_arb_pkg;

  typedef enum logic {
    STATE_IDLE   = 1'b0,
    STATE_LOCKED = 1'b1
  } lock_state_e;

  // Next source index after v, wrapping from n-1 back to 0.
  function automatic int unsigned mod_inc(input int unsigned v, input int unsigned n);
    if (v + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/svc_stream_arb_if.sv
// svc_stream_arb_if: bundle of the NUM_SRC requester streams and the merged
// output stream. The slave modport is the arbiter's view; master is the
// environment's view (producers plus the downstream consumer).
interface svc_stream_arb_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int SRC_WIDTH = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]            i_valid;
  logic [NUM_SRC*DATA_WIDTH-1:0] i_data;
  logic [NUM_SRC-1:0]            i_last;
  logic [NUM_SRC-1:0]            o_ready;
  logic                          o_valid;
  logic [DATA_WIDTH-1:0]         o_data;
  logic                          o_last;
  logic [SRC_WIDTH-1:0]          o_src;
  logic                          i_ready;

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last, o_src
  );

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_src
  );

endinterface

// File: rtl/svc_skidbuf.sv
// svc_skidbuf: one-entry skid buffer. Upstream ready depends only on a flop,
// so no combinational ready path crosses the buffer. With OPT_OUTREG=1 the
// output valid/data are also registered (two beats of storage in total).
module svc_skidbuf #(
  parameter int DATA_WIDTH = 8,
  parameter bit OPT_OUTREG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  assign o_ready = !skid_valid_q;

  if (OPT_OUTREG) begin : g_outreg
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  down_free_s;

    assign down_free_s = !out_valid_q || i_ready;
    assign o_valid     = out_valid_q;
    assign o_data      = out_data_q;

    // Move skid into the output register when it frees, else capture upstream.
    always_comb begin
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      if (down_free_s) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_data_d   = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (i_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = i_data;
        end else begin
          out_valid_d = 1'b0;
        end
      end else begin
        if (i_valid && !skid_valid_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = i_data;
        end else begin
          skid_valid_d = skid_valid_q;
        end
      end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end
  end else begin : g_comb
    assign o_valid = skid_valid_q || i_valid;
    assign o_data  = skid_valid_q ? skid_data_q : i_data;

    // Park a beat in the skid when downstream stalls; release on ready.
    always_comb begin
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (skid_valid_q) begin
        if (i_ready) begin
          skid_valid_d = 1'b0;
        end else begin
          skid_valid_d = 1'b1;
        end
      end else if (i_valid && !i_ready) begin
        skid_valid_d = 1'b1;
        skid_data_d  = i_data;
      end else begin
        skid_valid_d = 1'b0;
      end
    end
  end

  // Skid entry state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/svc_stream_arb.sv
// svc_stream_arb: round-robin arbiter merging NUM_SRC valid/ready streams into
// one registered output stream through svc_skidbuf.
// Optional feature macro SVC_STREAM_ARB_LOCK_EN: hold the grant on one source
// from its first beat until a beat with i_last=1 (packet locking).
module svc_stream_arb
  import svc_stream_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  svc_stream_arb_if.slave bus
);

  localparam int SRC_WIDTH = $clog2(NUM_SRC);
  localparam int BUF_WIDTH = DATA_WIDTH + SRC_WIDTH + 1;

  logic [SRC_WIDTH-1:0]  ptr_q, ptr_d;
  logic [SRC_WIDTH-1:0]  cand_s;
  logic                  search_valid_s;
  logic [SRC_WIDTH-1:0]  search_idx_s;
  logic                  grant_valid_s;
  logic [SRC_WIDTH-1:0]  grant_idx_s;
  logic [SRC_WIDTH-1:0]  ptr_next_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  sel_last_s;
  logic                  buf_ready_s;
  logic                  accept_s;
  logic [BUF_WIDTH-1:0]  buf_in_s;
  logic [BUF_WIDTH-1:0]  buf_out_s;

`ifdef SVC_STREAM_ARB_LOCK_EN
  lock_state_e          state_q, state_d;
  logic [SRC_WIDTH-1:0] lock_src_q, lock_src_d;
`endif

  // Round-robin search: first asserted valid starting at ptr, wrapping.
  always_comb begin
    search_valid_s = 1'b0;
    search_idx_s   = '0;
    cand_s         = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand_s = SRC_WIDTH'((int'(ptr_q) + i) % NUM_SRC);
      if (!search_valid_s && bus.i_valid[cand_s]) begin
        search_valid_s = 1'b1;
        search_idx_s   = cand_s;
      end else begin
        search_valid_s = search_valid_s;
      end
    end
  end

`ifdef SVC_STREAM_ARB_LOCK_EN
  // While a packet is open only its owner may be granted.
  always_comb begin
    if (state_q == STATE_LOCKED) begin
      grant_valid_s = bus.i_valid[lock_src_q];
      grant_idx_s   = lock_src_q;
    end else begin
      grant_valid_s = search_valid_s;
      grant_idx_s   = search_idx_s;
    end
  end
`else
  assign grant_valid_s = search_valid_s;
  assign grant_idx_s   = search_idx_s;
`endif

  // Steer the granted beat into the buffer and raise only its ready bit.
  always_comb begin
    sel_data_s  = '0;
    sel_last_s  = 1'b0;
    bus.o_ready = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_idx_s == SRC_WIDTH'(k)) begin
        sel_data_s     = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_last_s     = bus.i_last[k];
        bus.o_ready[k] = grant_valid_s && buf_ready_s && rst_n;
      end else begin
        bus.o_ready[k] = 1'b0;
      end
    end
  end

  assign accept_s   = grant_valid_s && buf_ready_s;
  assign ptr_next_s = SRC_WIDTH'(mod_inc(32'(grant_idx_s), NUM_SRC));
  assign buf_in_s   = {grant_idx_s, sel_last_s, sel_data_s};

  svc_skidbuf #(
    .DATA_WIDTH (BUF_WIDTH),
    .OPT_OUTREG (1'b1)
  ) u_skidbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (grant_valid_s),
    .o_ready (buf_ready_s),
    .i_data  (buf_in_s),
    .o_valid (bus.o_valid),
    .i_ready (bus.i_ready),
    .o_data  (buf_out_s)
  );

  assign bus.o_src  = buf_out_s[BUF_WIDTH-1 -: SRC_WIDTH];
  assign bus.o_last = buf_out_s[DATA_WIDTH];
  assign bus.o_data = buf_out_s[DATA_WIDTH-1:0];

  // Priority pointer and packet-lock next state.
  always_comb begin
    ptr_d = ptr_q;
`ifdef SVC_STREAM_ARB_LOCK_EN
    state_d    = state_q;
    lock_src_d = lock_src_q;
    if (accept_s) begin
      case (state_q)
        STATE_IDLE: begin
          if (sel_last_s) begin
            ptr_d = ptr_next_s;
          end else begin
            state_d    = STATE_LOCKED;
            lock_src_d = grant_idx_s;
          end
        end
        STATE_LOCKED: begin
          if (sel_last_s) begin
            state_d = STATE_IDLE;
            ptr_d   = ptr_next_s;
          end else begin
            state_d = STATE_LOCKED;
          end
        end
        default: begin
          state_d = STATE_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
`else
    if (accept_s) begin
      ptr_d = ptr_next_s;
    end else begin
      ptr_d = ptr_q;
    end
`endif
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
`ifdef SVC_STREAM_ARB_LOCK_EN
      state_q    <= STATE_IDLE;
      lock_src_q <= '0;
`endif
    end else begin
      ptr_q      <= ptr_d;
`ifdef SVC_STREAM_ARB_LOCK_EN
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
`endif
    end
  end

endmodule

// File: tb/tb_svc_stream_arb.sv
// tb_svc_stream_arb: randomized and directed stimulus for svc_stream_arb with a
// queue-based reference model. The driver predicts grants and pushes accepted
// beats into exp_q; an independent monitor compares the output stream.
module tb_svc_stream_arb;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] src;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk;
  logic rst_n;

  svc_stream_arb_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

  svc_stream_arb #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    vectors     = 0;
  int    miscompares = 0;
  beat_t exp_q[$];
  int    ptr         = 0;
`ifdef SVC_STREAM_ARB_LOCK_EN
  bit    locked      = 1'b0;
  int    lock_src    = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs, predict the grant, check o_ready, record the beat.
  task automatic drive(input logic [NS-1:0] v, input logic [NS*DW-1:0] d,
                       input logic [NS-1:0] l, input logic r);
    int          g;
    bit          gv;
    bit          search;
    bit          acc;
    logic [NS-1:0] exp_rdy;
    beat_t       nb;
    @(negedge clk);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_last  = l;
    bus.i_ready = r;
    #1;
    g      = 0;
    gv     = 1'b0;
    search = 1'b1;
`ifdef SVC_STREAM_ARB_LOCK_EN
    if (locked) begin
      search = 1'b0;
      g      = lock_src;
      gv     = v[g];
    end
`endif
    if (search) begin
      for (int i = 0; i < NS; i++) begin
        if (!gv && v[(ptr + i) % NS]) begin
          gv = 1'b1;
          g  = (ptr + i) % NS;
        end
      end
    end
    acc     = gv && (exp_q.size() < 2);
    exp_rdy = '0;
    if (acc) exp_rdy[g] = 1'b1;
    vectors++;
    if (bus.o_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL o_ready t=%0t got %b expected %b", $time, bus.o_ready, exp_rdy);
    end
    nb = '0;
    if (acc) begin
      nb.src  = SW'(g);
      nb.last = l[g];
      nb.data = d[g*DW +: DW];
`ifdef SVC_STREAM_ARB_LOCK_EN
      if (locked) begin
        if (l[g]) begin
          locked = 1'b0;
          ptr    = (g + 1) % NS;
        end
      end else if (l[g]) begin
        ptr = (g + 1) % NS;
      end else begin
        locked   = 1'b1;
        lock_src = g;
      end
`else
      ptr = (g + 1) % NS;
`endif
    end
    #2;
    if (acc) exp_q.push_back(nb);
  endtask

  function automatic logic [NS*DW-1:0] pattern_data(input int base);
    logic [NS*DW-1:0] d;
    for (int k = 0; k < NS; k++) d[k*DW +: DW] = DW'(base + k);
    return d;
  endfunction

  // Monitor: output must show the oldest outstanding beat; pop when consumed.
  initial begin
    beat_t b;
    bit    exp_v;
    forever begin
      @(negedge clk);
      #2;
      exp_v = (exp_q.size() != 0);
      vectors++;
      if (bus.o_valid !== exp_v) begin
        miscompares++;
        $display("FAIL o_valid t=%0t got %b expected %b", $time, bus.o_valid, exp_v);
      end
      if (exp_v) begin
        b = exp_q[0];
        vectors++;
        if ({bus.o_src, bus.o_last, bus.o_data} !== {b.src, b.last, b.data}) begin
          miscompares++;
          $display("FAIL beat t=%0t got src=%0d last=%b data=%h expected src=%0d last=%b data=%h",
                   $time, bus.o_src, bus.o_last, bus.o_data, b.src, b.last, b.data);
        end
        if (bus.i_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_zero(input string name, input logic [31:0] got);
    vectors++;
    if (got !== 32'd0) begin
      miscompares++;
      $display("FAIL %s got %h expected 0", name, got);
    end
  endtask

  // Main sequence.
  initial begin
    logic [NS*DW-1:0] d;
    rst_n       = 1'b0;
    bus.i_valid = 4'hF;
    bus.i_data  = pattern_data(32'h30);
    bus.i_last  = 4'h0;
    bus.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_zero("rst_o_valid", 32'(bus.o_valid));
    check_zero("rst_o_data",  32'(bus.o_data));
    check_zero("rst_o_last",  32'(bus.o_last));
    check_zero("rst_o_src",   32'(bus.o_src));
    check_zero("rst_o_ready", 32'(bus.o_ready));
    bus.i_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // All sources requesting: grants rotate 0,1,2,3,0,...
    for (int c = 0; c < 8; c++) drive(4'hF, pattern_data(32'h10), 4'h0, 1'b1);

    // Single source 2 with data A5, last set.
    d = '0;
    d[2*DW +: DW] = 8'hA5;
    drive(4'b0100, d, 4'b0100, 1'b1);
    drive(4'b0000, '0, 4'b0000, 1'b1);

    // Wrap: ptr now 3, sources 3 and 0 requesting.
    for (int c = 0; c < 3; c++) drive(4'b1001, pattern_data(32'h50), 4'hF, 1'b1);

    // Backpressure then release.
    for (int c = 0; c < 3; c++) drive(4'hF, pattern_data(32'h60), 4'h0, 1'b0);
    for (int c = 0; c < 8; c++) drive(4'hF, pattern_data(32'h60), 4'h0, 1'b1);

    // Packet test: park ptr on source 1, then sources 0 and 1 compete.
    for (int c = 0; c < 4; c++) drive(4'b0000, '0, 4'b0000, 1'b1);
    drive(4'b0001, pattern_data(32'h70), 4'b0001, 1'b1);
    for (int c = 0; c < 8; c++) begin
      logic [NS-1:0] l;
      l    = 4'b0001;
      l[1] = (c % 3 == 2);
      drive(4'b0011, pattern_data(32'h80 + c * 4), l, 1'b1);
    end

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic [NS-1:0] v;
      logic [NS-1:0] l;
      v = NS'($urandom_range(0, 15));
      l = NS'($urandom_range(0, 15));
      drive(v, {$urandom}, l, ($urandom_range(0, 3) != 0));
    end

    // Reset mid-stream with output occupied.
    for (int c = 0; c < 3; c++) drive(4'hF, pattern_data(32'h90), 4'h0, 1'b0);
    @(negedge clk);
    bus.i_valid = 4'hF;
    rst_n       = 1'b0;
    exp_q.delete();
    ptr = 0;
`ifdef SVC_STREAM_ARB_LOCK_EN
    locked = 1'b0;
`endif
    #1;
    check_zero("rst_mid_o_valid", 32'(bus.o_valid));
    check_zero("rst_mid_o_ready", 32'(bus.o_ready));
    @(negedge clk);
    bus.i_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) drive(4'hF, pattern_data(32'hA0), 4'hF, 1'b1);

    // Drain.
    for (int c = 0; c < 4; c++) drive(4'h0, '0, 4'h0, 1'b1);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d beats left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
